// File: rtl/mips_mem_unit.sv
// rtl/mips_mem_unit.sv - MIPS load/store unit bridging core requests to an Avalon-MM master
// Three-state sequencer: accept in IDLE, run one Avalon transfer in BUS, strobe the response in RESP.
module mips_mem_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam logic [16:0] TO_LIMIT  = 17'(TIMEOUT_CYCLES);
    localparam bit          TO_ENABLE = (TIMEOUT_CYCLES != 0);

    state_t      state_q, state_d;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_signed;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [15:0] wait_cnt;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_err;
    logic        timeout_hit;
    logic        in_bus;
    logic [3:0]  lane_be;
    logic [31:0] lane_wd;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign req_err = (req_size == 2'b11) ||
                     (ALIGN_CHECK && (((req_size == 2'b01) && req_addr[0]) ||
                                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))));

    // Fires on the stalled cycle that brings the count up to the limit.
    assign timeout_hit = TO_ENABLE && waitrequest && (({1'b0, wait_cnt} + 17'd1) == TO_LIMIT);

    always_comb begin
        lane_be = 4'b1111;
        lane_wd = lat_wdata;
        case (lat_size)
            2'b00: begin
                lane_be = 4'b0001 << lat_addr[1:0];
                lane_wd = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                lane_be = lat_addr[1] ? 4'b1100 : 4'b0011;
                lane_wd = {2{lat_wdata[15:0]}};
            end
            default: begin
                lane_be = 4'b1111;
                lane_wd = lat_wdata;
            end
        endcase
    end

    always_comb begin
        shifted  = 32'd0;
        load_ext = readdata;
        case (lat_size)
            2'b00: begin
                shifted  = readdata >> {lat_addr[1:0], 3'b000};
                load_ext = {{24{lat_signed & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                shifted  = readdata >> {lat_addr[1], 4'b0000};
                load_ext = {{16{lat_signed & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                shifted  = readdata;
                load_ext = readdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = req_err ? S_RESP : S_BUS;
            S_BUS:  if (!waitrequest || timeout_hit) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_signed <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            wait_cnt   <= 16'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        lat_write  <= req_write;
                        lat_size   <= req_size;
                        lat_signed <= req_signed;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        wait_cnt   <= 16'd0;
                        rdata_q    <= 32'd0;
                        err_q      <= req_err;
                    end
                end
                S_BUS: begin
                    if (!waitrequest) begin
                        rdata_q <= lat_write ? 32'd0 : load_ext;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_bus     = (state_q == S_BUS);
    assign req_ready  = (state_q == S_IDLE);
    assign read       = in_bus && !lat_write;
    assign write      = in_bus && lat_write;
    assign address    = in_bus ? {lat_addr[31:2], 2'b00} : 32'd0;
    assign byteenable = in_bus ? lane_be : 4'd0;
    assign writedata  = (in_bus && lat_write) ? lane_wd : 32'd0;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;
    assign resp_error = resp_valid && err_q;

endmodule

// File: tb/tb_mips_mem_unit.sv
// tb/tb_mips_mem_unit.sv - directed vector bench for mips_mem_unit
module tb_mips_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid0;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr, req_wdata;
    logic        waitrequest, waitrequest0;
    logic [31:0] readdata;

    logic        req_ready, resp_valid, resp_error, read, write;
    logic [31:0] resp_rdata, address, writedata;
    logic [3:0]  byteenable;

    logic        req_ready0, resp_valid0, resp_error0, read0, write0;
    logic [31:0] resp_rdata0, address0, writedata0;
    logic [3:0]  byteenable0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_mem_unit #(.TIMEOUT_CYCLES(4), .ALIGN_CHECK(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .address(address), .read(read), .write(write),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata)
    );

    mips_mem_unit #(.TIMEOUT_CYCLES(0), .ALIGN_CHECK(1'b0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .resp_error(resp_error0), .address(address0), .read(read0), .write(write0),
        .waitrequest(waitrequest0), .writedata(writedata0), .byteenable(byteenable0),
        .readdata(readdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic        exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
        req_write   = v.wr;
        req_size    = v.size;
        req_signed  = v.sgn;
        req_addr    = v.addr;
        req_wdata   = v.wdata;
        readdata    = v.rdata;
        waitrequest = (v.waits != 0);
        req_valid   = 1'b1;
        @(posedge clk); #1;
        // Scramble the request bus so any use of unlatched fields shows up.
        req_write  = ~v.wr;
        req_size   = 2'b00;
        req_signed = ~v.sgn;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5555_5555;
        if (v.exp_err) begin
            req_valid = 1'b0;
            chk($sformatf("v%0d err strobes", idx), {30'd0, read, write}, 32'd0);
            chk($sformatf("v%0d err resp_valid", idx), 32'(resp_valid), 32'd1);
            chk($sformatf("v%0d err resp_error", idx), 32'(resp_error), 32'd1);
            chk($sformatf("v%0d err rdata", idx), resp_rdata, 32'd0);
        end else begin
            for (int i = 0; i <= v.waits; i++) begin
                waitrequest = (i < v.waits);
                chk($sformatf("v%0d c%0d strobes", idx, i), {30'd0, read, write}, {30'd0, ~v.wr, v.wr});
                chk($sformatf("v%0d c%0d address", idx, i), address, v.exp_addr);
                chk($sformatf("v%0d c%0d be", idx, i), 32'(byteenable), 32'(v.exp_be));
                if (v.wr) chk($sformatf("v%0d c%0d wdata", idx, i), writedata, v.exp_wd);
                chk($sformatf("v%0d c%0d busy", idx, i), {30'd0, req_ready, resp_valid}, 32'd0);
                @(posedge clk); #1;
            end
            req_valid = 1'b0;
            chk($sformatf("v%0d resp_valid", idx), 32'(resp_valid), 32'd1);
            chk($sformatf("v%0d resp_error", idx), 32'(resp_error), 32'd0);
            chk($sformatf("v%0d resp_rdata", idx), resp_rdata, v.exp_rdata);
            chk($sformatf("v%0d strobes off", idx), {30'd0, read, write}, 32'd0);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d after resp", idx), {30'd0, req_ready, resp_valid}, 32'd2);
        chk($sformatf("v%0d rdata idle", idx), resp_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic bad;

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 4'hF, 32'h0, 32'h1000_0004, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'h0, 32'h8000_0000, 0, 1'b0, 4'h8, 32'h0, 32'h1000_0000, 32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'h0, 32'h8000_0000, 1, 1'b0, 4'h8, 32'h0, 32'h1000_0000, 32'h0000_0080};
        vecs[3]  = '{1'b1, 2'd1, 1'b0, 32'h1000_0002, 32'h0000_1234, 32'h0, 3, 1'b0, 4'hC, 32'h1234_1234, 32'h1000_0000, 32'h0};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h1000_0001, 32'h0, 32'h1111_1111, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 32'h2000_0001, 32'h1234_56AB, 32'h0, 0, 1'b0, 4'h2, 32'hABAB_ABAB, 32'h2000_0000, 32'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0, 32'h1234_8001, 2, 1'b0, 4'h3, 32'h0, 32'h0, 32'hFFFF_8001};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0002, 32'h0, 32'h8765_0000, 0, 1'b0, 4'hC, 32'h0, 32'h0, 32'h0000_8765};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0002, 32'h0, 32'h7FFF_0000, 0, 1'b0, 4'hC, 32'h0, 32'h0, 32'h0000_7FFF};
        vecs[9]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h2222_2222, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 0, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 2, 1'b0, 4'hF, 32'hCAFE_F00D, 32'h0000_0040, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_5A00, 0, 1'b0, 4'h2, 32'h0, 32'h0, 32'h0000_005A};
        vecs[13] = '{1'b0, 2'd0, 1'b1, 32'h0000_0006, 32'h0, 32'h00C3_0000, 1, 1'b0, 4'h4, 32'h0, 32'h0000_0004, 32'hFFFF_FFC3};

        reset = 1'b0; req_valid = 1'b0; req_valid0 = 1'b0;
        req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; readdata = 32'h0;
        waitrequest = 1'b0; waitrequest0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset strobes", {29'd0, read, write, resp_valid}, 32'd0);
        chk("reset address", address, 32'd0);
        chk("reset be", 32'(byteenable), 32'd0);
        chk("reset resp", {resp_rdata[30:0], resp_error}, 32'd0);

        for (int i = 0; i < 14; i++) run_txn(i, vecs[i]);

        // Timeout after four stalled cycles.
        req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0100; readdata = 32'h3333_3333;
        waitrequest = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) break;
            if (read) cnt++;
            @(posedge clk); #1;
        end
        chk("timeout read cycles", 32'(cnt), 32'd4);
        chk("timeout resp_valid", 32'(resp_valid), 32'd1);
        chk("timeout resp_error", 32'(resp_error), 32'd1);
        chk("timeout rdata", resp_rdata, 32'd0);
        chk("timeout strobes", {30'd0, read, write}, 32'd0);
        waitrequest = 1'b0;
        @(posedge clk); #1;
        chk("timeout back idle", 32'(req_ready), 32'd1);

        // Reset during a bus stall aborts without a response.
        req_write = 1'b0; req_size = 2'd0; req_addr = 32'h0000_0033; waitrequest = 1'b1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort read before reset", 32'(read), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort read dropped", {31'd0, read}, 32'd0);
        chk("abort address cleared", address, 32'd0);
        #2 reset = 1'b1;
        waitrequest = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid || read) bad = 1'b1;
        end
        chk("abort no response", 32'(bad), 32'd0);
        run_txn(100, vecs[0]);

        // Timeout disabled: a long stall simply waits.
        req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0200; waitrequest0 = 1'b1; req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!read0 || resp_valid0) bad = 1'b1;
            @(posedge clk); #1;
        end
        chk("no-timeout held", 32'(bad), 32'd0);
        waitrequest0 = 1'b0;
        readdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        chk("no-timeout resp_valid", 32'(resp_valid0), 32'd1);
        chk("no-timeout resp_error", 32'(resp_error0), 32'd0);
        chk("no-timeout rdata", resp_rdata0, 32'h0BAD_F00D);
        @(posedge clk); #1;

        // Alignment checking off: a misaligned word goes to the bus.
        req_addr = 32'h0000_0201; req_size = 2'd2; req_valid0 = 1'b1;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        chk("noalign read", 32'(read0), 32'd1);
        chk("noalign address", address0, 32'h0000_0200);
        chk("noalign be", 32'(byteenable0), 32'hF);
        @(posedge clk); #1;
        chk("noalign resp", {30'd0, resp_valid0, resp_error0}, 32'd2);
        chk("noalign rdata", resp_rdata0, 32'h0BAD_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
